simon_round_datapath_serial: RTL and testbench
==============================================

# simon_round_datapath_serial

Bit-serial SIMON128/128 round datapath. It holds the 128-bit block state (x, y), loads plaintext and unloads ciphertext over a shared serial path, and executes one round every 64 cycles. It sits directly downstream of the key-expansion shift register: it consumes that block's `key_out` bit stream together with the shared `data_rdy` and `bit_counter` controls, plus the key block's `round_counter`.

## Interface
- `NROUNDS`, default 68: number of rounds executed before `done` asserts.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `data_in`  in  1  serial plaintext bit, used in load mode.
- `key_in`  in  1  round-key bit k_r[j], from key expansion `key_out`, valid in the same cycle.
- `data_rdy`  in  2  mode:
  - 0: idle
  - 1: block load/unload
  - 2: hold (key load in progress)
  - 3: encrypt
- `bit_counter`  in  6  bit index j of the current round, 0..63.
- `round_counter`  in  7  current round index r.
- `cipher_out`  out  1  serial output bit, equal to Y[0].
- `done`  out  1  high once round NROUNDS-1 has completed.

## Operation
- State: X[63:0] and Y[63:0]. Reset clears X, Y and `done` to 0, so `cipher_out` is 0.
- Mode 0 / mode 2: X and Y hold.
  - In mode 0 the upstream `round_counter` returns to 0.
- Mode 1, load/unload:
  - X, Y form one 128-bit chain: `data_in`→X[63]→…→X[0]→Y[63]→…→Y[0]→`cipher_out`.
  - Load order over 128 cycles is y LSB first, then x LSB first.
  - The previous ciphertext leaves on `cipher_out` in the same order, y bits then x bits, LSB first.
  - `done` clears on the first mode-1 cycle.
- Mode 3, encrypt, at bit j with x_j = X[0]:
  - Tap for offset k: T_k = X[64-k] if j<k, else Y[64-k]. This covers the wrap-around of the old x.
  - f_j = (T_1 & T_8) ^ T_2.
  - x'_j = Y[0] ^ f_j ^ `key_in`.
  - Shift X <= {x'_j, X[63:1]} and Y <= {X[0], Y[63:1]}.
  - After 64 cycles (j = 0..63) X = x' and Y = x, which is one SIMON round.
- `done` sets on the cycle after a mode-3 cycle with `round_counter`==NROUNDS-1 and `bit_counter`==63.
- `done` stays set until mode 1 or reset.
- Upstream controller contract:
  - `bit_counter` is 0 at the first mode-3 cycle of each round and increments by 1 per mode-3 cycle.
  - Any other sequence yields undefined cipher output; this is not checked in RTL.

## Timing
- Load: 128 mode-1 cycles. Encrypt: NROUNDS×64 mode-3 cycles, which is 4352 for the default.
- `key_in` is combinational into x'_j and must be stable in the same cycle as `bit_counter`=j.
- `cipher_out` is registered: Y[0] appears on the output directly, with no extra pipeline.
- Reset mid-load or mid-encrypt aborts the operation. The state is zeroed on the next edge, and `done`=0.
- Mode change mid-round (3→2 or 3→0) freezes the partial state. Resuming in mode 3 at the same `bit_counter` continues correctly.
- `done` and mode 1 in the same cycle: mode 1 wins, so `done` clears and the chain shifts.

## Configuration
- `SIMON_DONE_FREEZE_EN`:
  - Defined: while `done`=1, mode 3 does not update X/Y, so the ciphertext is protected against overrun rounds.
  - Undefined: mode 3 keeps executing rounds regardless of `done`. `done` still sets exactly once, as specified.

## Test plan
- Reset with X/Y nonzero → X=Y=0, `done`=0, `cipher_out`=0 on the next edge.
- Single-round check (`key_in` driven directly):
  - Stimulus: load x=0x0000000000000001, y=0, `key_in`=0, 64 mode-3 cycles.
  - Response: X=0x0000000000000004, Y=0x0000000000000001.
- Wrap-tap check:
  - Stimulus: x=0x8000000000000000, y=0, k=0, one round.
  - Response: X=0x0000000000000002 (S² term from bit 63), Y=0x8000000000000000.
- Full vector with the key-expansion block:
  - Key 0x0f0e0d0c0b0a0908_0706050403020100; pt x=0x6373656420737265, y=0x6c6c657661727420.
  - After 68 rounds: `done`=1; x=0x49681b1e1e54fe3f, y=0x65aa832af84e0bbc.
  - Unload via mode 1: y LSB first.
- Overrun with the macro defined: 64 extra mode-3 cycles after `done` → X/Y unchanged. Without the macro → X/Y change to the next round value.
- Reset asserted at round 30, bit 17 → state zeroed. A reload with the same vector then reproduces the ciphertext.

Source files
------------

// File: rtl/simon_round_datapath_serial_if.sv
// Serial control and data bundle between the SIMON key-expansion/controller side
// (master) and the bit-serial round datapath (slave).
interface simon_round_datapath_serial_if;
    logic       data_in;
    logic       key_in;
    logic [1:0] data_rdy;
    logic [5:0] bit_counter;
    logic [6:0] round_counter;
    logic       cipher_out;
    logic       done;

    modport master (
        output data_in, key_in, data_rdy, bit_counter, round_counter,
        input  cipher_out, done
    );

    modport slave (
        input  data_in, key_in, data_rdy, bit_counter, round_counter,
        output cipher_out, done
    );
endinterface

// File: rtl/simon_round_datapath_serial.sv
// Bit-serial SIMON128/128 round datapath: one round per 64 encrypt cycles, 128-cycle
// serial load/unload chain. Optional macro SIMON_DONE_FREEZE_EN blocks rounds while done=1.
module simon_round_datapath_serial #(
    parameter int NROUNDS = 68
) (
    input  logic                          clk,
    input  logic                          reset,
    simon_round_datapath_serial_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_LOAD = 2'd1,
        MODE_HOLD = 2'd2,
        MODE_ENC  = 2'd3
    } mode_e;

    localparam logic [6:0] LAST_ROUND = 7'(NROUNDS - 1);

    mode_e       mode;
    logic [63:0] x_q;
    logic [63:0] y_q;
    logic        done_q;
    logic        tap1;
    logic        tap2;
    logic        tap8;
    logic        x_new;
    logic        enc_en;
    logic        shift_en;
    logic        x_head;
    logic        last_bit;

    assign mode = mode_e'(bus.data_rdy);

    // Early in a round the rotated taps still sit in X (not yet shifted into Y).
    // NOTE: every signal gets a value on every path here, so no latch is inferred.
    always_comb begin
        tap1  = (bus.bit_counter < 6'd1) ? x_q[63] : y_q[63];
        tap2  = (bus.bit_counter < 6'd2) ? x_q[62] : y_q[62];
        tap8  = (bus.bit_counter < 6'd8) ? x_q[56] : y_q[56];
        x_new = y_q[0] ^ ((tap1 & tap8) ^ tap2) ^ bus.key_in;
    end

`ifdef SIMON_DONE_FREEZE_EN
    assign enc_en = (mode == MODE_ENC) && !done_q;
`else
    assign enc_en = (mode == MODE_ENC);
`endif

    assign shift_en = (mode == MODE_LOAD) || enc_en;
    assign x_head   = (mode == MODE_LOAD) ? bus.data_in : x_new;
    assign last_bit = (mode == MODE_ENC) && (bus.round_counter == LAST_ROUND)
                      && (bus.bit_counter == 6'd63);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q    <= '0;
            y_q    <= '0;
            done_q <= 1'b0;
        end else begin
            if (shift_en) begin
                x_q <= {x_head, x_q[63:1]};
                y_q <= {x_q[0], y_q[63:1]};
            end
            if (mode == MODE_LOAD) begin
                done_q <= 1'b0;
            end else if (last_bit) begin
                done_q <= 1'b1;
            end
        end
    end

    assign bus.cipher_out = y_q[0];
    assign bus.done       = done_q;

endmodule

// File: tb/tb_simon_round_datapath_serial.sv
// Directed bench for the bit-serial SIMON128/128 round datapath, with a word-level
// key schedule generating the round-key bit stream.
module tb_simon_round_datapath_serial;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [63:0] rk [0:68];
    logic [63:0] gx, gy, ex, ey;

    simon_round_datapath_serial_if bus ();

    simon_round_datapath_serial #(.NROUNDS(68)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rol(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Shift in a new block (y then x, LSB first) while capturing the old one.
    task automatic load_unload(input logic [63:0] nx, input logic [63:0] ny,
                               output logic [63:0] ox, output logic [63:0] oy);
        logic [63:0] tx, ty;
        tx = '0;
        ty = '0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (i < 64) ty[i] = bus.cipher_out;
            else        tx[i-64] = bus.cipher_out;
            bus.data_rdy = 2'd1;
            bus.data_in  = (i < 64) ? ny[i] : nx[i-64];
        end
        @(negedge clk);
        bus.data_rdy = 2'd0;
        bus.data_in  = 1'b0;
        ox = tx;
        oy = ty;
    endtask

    // Run rounds first..last; optionally pause (modes 2 then 0) or reset at a given bit.
    task automatic encrypt_rounds(input int first, input int last,
                                  input int pause_r, input int pause_b,
                                  input int abort_r, input int abort_b);
        for (int r = first; r <= last; r++) begin
            for (int j = 0; j < 64; j++) begin
                if (r == pause_r && j == pause_b) begin
                    repeat (2) begin
                        @(negedge clk);
                        bus.data_rdy    = 2'd2;
                        bus.bit_counter = 6'd5;
                        bus.key_in      = ~bus.key_in;
                    end
                    @(negedge clk);
                    bus.data_rdy      = 2'd0;
                    bus.round_counter = 7'd0;
                end
                if (r == abort_r && j == abort_b) begin
                    @(negedge clk);
                    reset = 1'b0;
                    @(negedge clk);
                    reset             = 1'b1;
                    bus.data_rdy      = 2'd0;
                    bus.round_counter = 7'd0;
                    return;
                end
                @(negedge clk);
                bus.data_rdy      = 2'd3;
                bus.bit_counter   = 6'(j);
                bus.round_counter = 7'(r);
                bus.key_in        = rk[r][j];
            end
        end
        @(negedge clk);
        bus.data_rdy      = 2'd0;
        bus.round_counter = 7'd0;
    endtask

    initial begin
        logic [63:0] tmp;
        logic [63:0] z2;
        logic [63:0] pt_x, pt_y, ct_x, ct_y;
        pt_x = 64'h6373656420737265;
        pt_y = 64'h6c6c657661727420;
        ct_x = 64'h49681b1e1e54fe3f;
        ct_y = 64'h65aa832af84e0bbc;
        z2   = 64'h3369F885192C0EF5;

        // Key schedule for key 0x0f0e0d0c0b0a0908_0706050403020100 (m = 2).
        rk[0] = 64'h0706050403020100;
        rk[1] = 64'h0f0e0d0c0b0a0908;
        for (int i = 0; i < 66; i++) begin
            tmp = ror(rk[i+1], 3);
            tmp = tmp ^ ror(tmp, 1);
            rk[i+2] = ~rk[i] ^ tmp ^ {63'd0, z2[i % 62]} ^ 64'd3;
        end
        rk[68] = '0;

        bus.data_in       = 1'b0;
        bus.key_in        = 1'b0;
        bus.data_rdy      = 2'd0;
        bus.bit_counter   = 6'd0;
        bus.round_counter = 7'd0;

        repeat (2) @(negedge clk);
        check("reset_cipher_out", {63'd0, bus.cipher_out}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        reset = 1'b1;

        // Single round, x=1, y=0, key 0.
        load_unload(64'd1, 64'd0, gx, gy);
        check("reset_state_x", gx, 64'd0);
        check("reset_state_y", gy, 64'd0);
        rk[0] = 64'd0;
        encrypt_rounds(0, 0, -1, -1, -1, -1);
        check("one_round_done", {63'd0, bus.done}, 64'd0);

        // Wrap-tap round, x=0x8000..., y=0.
        load_unload(64'h8000000000000000, 64'd0, gx, gy);
        check("one_round_x", gx, 64'h0000000000000004);
        check("one_round_y", gy, 64'h0000000000000001);
        encrypt_rounds(0, 0, -1, -1, -1, -1);
        rk[0] = 64'h0706050403020100;

        // Full vector, with a mid-round freeze in round 5.
        load_unload(pt_x, pt_y, gx, gy);
        check("wrap_round_x", gx, 64'h0000000000000002);
        check("wrap_round_y", gy, 64'h8000000000000000);
        encrypt_rounds(0, 66, 5, 30, -1, -1);
        check("done_before_last", {63'd0, bus.done}, 64'd0);
        encrypt_rounds(67, 67, -1, -1, -1, -1);
        check("done_after_last", {63'd0, bus.done}, 64'd1);
        repeat (3) @(negedge clk);
        check("done_holds_idle", {63'd0, bus.done}, 64'd1);

        load_unload(pt_x, pt_y, gx, gy);
        check("cipher_x", gx, ct_x);
        check("cipher_y", gy, ct_y);
        check("done_cleared_by_load", {63'd0, bus.done}, 64'd0);

        // Reset mid-encrypt at round 30, bit 17, then redo the vector.
        encrypt_rounds(0, 67, -1, -1, 30, 17);
        check("abort_cipher_out", {63'd0, bus.cipher_out}, 64'd0);
        check("abort_done", {63'd0, bus.done}, 64'd0);
        load_unload(pt_x, pt_y, gx, gy);
        check("abort_state_x", gx, 64'd0);
        check("abort_state_y", gy, 64'd0);
        encrypt_rounds(0, 67, -1, -1, -1, -1);
        check("redo_done", {63'd0, bus.done}, 64'd1);

        // Overrun: one more round with key 0 after done.
        encrypt_rounds(68, 68, -1, -1, -1, -1);
        check("overrun_done", {63'd0, bus.done}, 64'd1);
`ifdef SIMON_DONE_FREEZE_EN
        ex = ct_x;
        ey = ct_y;
`else
        ex = ct_y ^ ((rol(ct_x, 1) & rol(ct_x, 8)) ^ rol(ct_x, 2));
        ey = ct_x;
`endif
        load_unload(64'd0, 64'd0, gx, gy);
        check("overrun_x", gx, ex);
        check("overrun_y", gy, ey);
        check("final_done", {63'd0, bus.done}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
